// File: rtl/width_cfg_responder.sv
// width_cfg_responder: responder side of the width-configuration protocol.
// Range-checks a requested data width, applies it to the held active
// configuration over a fixed apply window (which abort can cancel), and
// returns a result code over a valid/ready response channel.
// Optional build macro CFG_RSP_STATS_EN adds saturating per-result counters.
module width_cfg_responder #(
    parameter int unsigned WIDTH_BITS    = 8,
    parameter int unsigned MIN_WIDTH     = 8,
    parameter int unsigned MAX_WIDTH     = 64,
    parameter int unsigned DEFAULT_WIDTH = 32,
    parameter int unsigned APPLY_CYCLES  = 4,
    parameter int unsigned ID_BITS       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WIDTH_BITS-1:0] req_width,
    input  logic [ID_BITS-1:0]    req_id,
    input  logic                  abort,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_result,
    output logic [ID_BITS-1:0]    rsp_id,
    output logic [WIDTH_BITS-1:0] rsp_width,
    output logic [WIDTH_BITS-1:0] cfg_max_width,
    output logic [1:0]            status
`ifdef CFG_RSP_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_success,
    output logic [15:0]           stat_failure,
    output logic [15:0]           stat_error
`endif
);

    localparam int unsigned CntW = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;

    localparam logic [WIDTH_BITS-1:0] MinW     = WIDTH_BITS'(MIN_WIDTH);
    localparam logic [WIDTH_BITS-1:0] MaxW     = WIDTH_BITS'(MAX_WIDTH);
    localparam logic [WIDTH_BITS-1:0] DefW     = WIDTH_BITS'(DEFAULT_WIDTH);
    localparam logic [CntW-1:0]       CntLoad  = CntW'(APPLY_CYCLES - 1);

    localparam logic [1:0] ResSuccess = 2'b00;
    localparam logic [1:0] ResFailure = 2'b01;
    localparam logic [1:0] ResPending = 2'b10;
    localparam logic [1:0] ResError   = 2'b11;

    typedef enum logic [1:0] {StIdle, StCheck, StApply, StResp} state_e;

    state_e                state_q, state_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic [ID_BITS-1:0]    id_q, id_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            result_q, result_d;
    logic [WIDTH_BITS-1:0] cfg_q, cfg_d;
    logic                  in_range;

    // Full-width unsigned compare, so values above MAX_WIDTH never alias into range.
    assign in_range = (width_q >= MinW) && (width_q <= MaxW);

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            width_q  <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            result_q <= ResSuccess;
            cfg_q    <= DefW;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cfg_q    <= cfg_d;
        end
    end

    // Next-state logic: accept, range check, timed apply with abort, response hold.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cfg_d    = cfg_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    width_d = req_width;
                    id_d    = req_id;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (in_range) begin
                    cnt_d   = CntLoad;
                    state_d = StApply;
                end else begin
                    result_d = ResFailure;
                    state_d  = StResp;
                end
            end
            StApply: begin
                // Abort wins even on the final cycle: the config is left untouched.
                if (abort) begin
                    result_d = ResError;
                    state_d  = StResp;
                end else if (cnt_q == '0) begin
                    cfg_d    = width_q;
                    result_d = ResSuccess;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready     = (state_q == StIdle);
    assign rsp_valid     = (state_q == StResp);
    assign rsp_result    = result_q;
    assign rsp_id        = id_q;
    assign rsp_width     = cfg_q;
    assign cfg_max_width = cfg_q;
    assign status        = ((state_q == StCheck) || (state_q == StApply)) ? ResPending
                                                                          : ResSuccess;

`ifdef CFG_RSP_STATS_EN
    logic        rsp_done;
    logic [15:0] succ_q, fail_q, err_q;

    assign rsp_done = rsp_valid && rsp_ready;

    // Saturating result counters; clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            succ_q <= '0;
            fail_q <= '0;
            err_q  <= '0;
        end else if (stat_clr) begin
            succ_q <= '0;
            fail_q <= '0;
            err_q  <= '0;
        end else if (rsp_done) begin
            if ((result_q == ResSuccess) && (succ_q != 16'hFFFF)) succ_q <= succ_q + 16'd1;
            if ((result_q == ResFailure) && (fail_q != 16'hFFFF)) fail_q <= fail_q + 16'd1;
            if ((result_q == ResError) && (err_q != 16'hFFFF))    err_q  <= err_q + 16'd1;
        end
    end

    assign stat_success = succ_q;
    assign stat_failure = fail_q;
    assign stat_error   = err_q;
`endif

endmodule

// File: tb/tb_width_cfg_responder.sv
// Self-checking bench for width_cfg_responder: directed requests with
// hand-computed latencies/results plus a per-cycle transaction-level model.
// Stats counters are exercised when CFG_RSP_STATS_EN is defined.
module tb_width_cfg_responder;

    localparam int APPLY = 4;
    localparam int DEFW  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_width = '0;
    logic [3:0] req_id = '0;
    logic       abort = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_result;
    logic [3:0] rsp_id;
    logic [7:0] rsp_width;
    logic [7:0] cfg_max_width;
    logic [1:0] status;
`ifdef CFG_RSP_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_success, stat_failure, stat_error;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pend_abort = 0;

    width_cfg_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_width    (req_width),
        .req_id       (req_id),
        .abort        (abort),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_id       (rsp_id),
        .rsp_width    (rsp_width),
        .cfg_max_width(cfg_max_width),
        .status       (status)
`ifdef CFG_RSP_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_success (stat_success),
        .stat_failure (stat_failure),
        .stat_error   (stat_error)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, response due at a fixed
    // cycle offset from acceptance, config updated only on success.
    logic       m_busy = 1'b0;
    int         m_k, m_rsp_at;
    logic [7:0] m_width, m_cfg = 8'(DEFW);
    logic [3:0] m_id;
    logic [1:0] m_res;
    int         m_succ = 0, m_failc = 0, m_err = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cfg  = 8'(DEFW);
            m_succ = 0; m_failc = 0; m_err = 0;
            check("rst_req_ready", 32'(req_ready), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_result", 32'(rsp_result), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("rst_rsp_width", 32'(rsp_width), 32'(DEFW));
            check("rst_status", 32'(status), 32'd0);
            check("rst_cfg", 32'(cfg_max_width), 32'(DEFW));
        end else begin
            if (m_busy) begin
                m_k++;
                if (m_k == m_rsp_at && m_res == 2'b00) m_cfg = m_width;
                check("mdl_req_ready", 32'(req_ready), 32'd0);
                if (m_k < m_rsp_at) begin
                    check("mdl_rsp_valid", 32'(rsp_valid), 32'd0);
                    check("mdl_status", 32'(status), 32'd2);
                end else begin
                    check("mdl_rsp_valid", 32'(rsp_valid), 32'd1);
                    check("mdl_status", 32'(status), 32'd0);
                    check("mdl_rsp_result", 32'(rsp_result), 32'(m_res));
                    check("mdl_rsp_id", 32'(rsp_id), 32'(m_id));
                    check("mdl_rsp_width", 32'(rsp_width), 32'(m_cfg));
                end
            end else begin
                check("mdl_req_ready", 32'(req_ready), 32'd1);
                check("mdl_rsp_valid", 32'(rsp_valid), 32'd0);
                check("mdl_status", 32'(status), 32'd0);
            end
            check("mdl_cfg", 32'(cfg_max_width), 32'(m_cfg));
`ifdef CFG_RSP_STATS_EN
            check("mdl_stat_success", 32'(stat_success), 32'(m_succ));
            check("mdl_stat_failure", 32'(stat_failure), 32'(m_failc));
            check("mdl_stat_error", 32'(stat_error), 32'(m_err));
`endif
            // Advance the model to what the next cycle must show.
            if (m_busy && m_k >= m_rsp_at && rsp_ready) begin
                m_busy = 1'b0;
                if (m_res == 2'b00 && m_succ < 65535) m_succ++;
                if (m_res == 2'b01 && m_failc < 65535) m_failc++;
                if (m_res == 2'b11 && m_err < 65535) m_err++;
            end else if (!m_busy && req_valid) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_width = req_width;
                m_id    = req_id;
                if (req_width < 8 || req_width > 64) begin
                    m_rsp_at = 2; m_res = 2'b01;
                end else if (pend_abort != 0) begin
                    m_rsp_at = 2 + pend_abort; m_res = 2'b11;
                end else begin
                    m_rsp_at = 2 + APPLY; m_res = 2'b00;
                end
            end
`ifdef CFG_RSP_STATS_EN
            if (stat_clr) begin
                m_succ = 0; m_failc = 0; m_err = 0;
            end
`endif
        end
    end

    // One request; inputs change #1 after posedge. Cycle 1 is the cycle after the accept edge.
    task automatic do_req(input logic [7:0] w, input logic [3:0] id, input int abort_at,
                          input int hold, input int exp_lat, input logic [1:0] exp_res,
                          input logic [7:0] exp_cfg);
        int n;
        pend_abort = abort_at;
        rsp_ready  = (hold == 0);
        req_width  = w;
        req_id     = id;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            abort = (abort_at != 0) && (n == 1 + abort_at);
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b0;
        check("latency", 32'(n), 32'(exp_lat));
        check("result", 32'(rsp_result), 32'(exp_res));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("cfg", 32'(cfg_max_width), 32'(exp_cfg));
        check("rsp_width", 32'(rsp_width), 32'(exp_cfg));
        if (hold > 0) begin
            req_width = 8'd9;
            req_id    = ~id;
            req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                check("hold_req_ready", 32'(req_ready), 32'd0);
                check("hold_result", 32'(rsp_result), 32'(exp_res));
                check("hold_id", 32'(rsp_id), 32'(id));
                check("hold_width", 32'(rsp_width), 32'(exp_cfg));
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        pend_abort = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cfg", 32'(cfg_max_width), 32'd32);

        do_req(8'd16,  4'd3, 0, 0, 6, 2'b00, 8'd16);
        do_req(8'd7,   4'd1, 0, 0, 2, 2'b01, 8'd16);
        do_req(8'd65,  4'd2, 0, 0, 2, 2'b01, 8'd16);
        do_req(8'd8,   4'd4, 0, 0, 6, 2'b00, 8'd8);
        do_req(8'd64,  4'd5, 0, 0, 6, 2'b00, 8'd64);
        do_req(8'd48,  4'd6, 2, 0, 4, 2'b11, 8'd64);
        do_req(8'd48,  4'd7, 4, 0, 6, 2'b11, 8'd64);
        do_req(8'd24,  4'd8, 0, 5, 6, 2'b00, 8'd24);
        do_req(8'd0,   4'd9, 0, 0, 2, 2'b01, 8'd24);
        do_req(8'd255, 4'hA, 0, 0, 2, 2'b01, 8'd24);

        // Reset while applying width 40: no response, config back to default.
        req_width = 8'd40; req_id = 4'hB; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("apply_status", 32'(status), 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_cfg", 32'(cfg_max_width), 32'd32);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("midrst_ready_after", 32'(req_ready), 32'd1);
        check("midrst_cfg_after", 32'(cfg_max_width), 32'd32);

`ifdef CFG_RSP_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        do_req(8'd20,  4'd1, 0, 0, 6, 2'b00, 8'd20);
        do_req(8'd30,  4'd2, 0, 0, 6, 2'b00, 8'd30);
        do_req(8'd100, 4'd3, 0, 0, 2, 2'b01, 8'd30);
        do_req(8'd50,  4'd4, 1, 0, 3, 2'b11, 8'd30);
        check("stat_success", 32'(stat_success), 32'd2);
        check("stat_failure", 32'(stat_failure), 32'd1);
        check("stat_error", 32'(stat_error), 32'd1);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("clr_success", 32'(stat_success), 32'd0);
        check("clr_failure", 32'(stat_failure), 32'd0);
        check("clr_error", 32'(stat_error), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
